// File: rtl/hs32_pkg.sv
// hs32_pkg: shared definitions for the hs32 memory target.
//   hs32_state_t : target FSM state encoding
//   RW_READ/WRITE: access type encoding carried on the rw port
//   CNT_W        : width of the wait-state counter (covers 0..15)
package hs32_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } hs32_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/hs32_bram.sv
// hs32_bram: single-port synchronous RAM, 2^AW x 32 bits, 1-cycle read.
//   clk  : clock
//   we   : write enable for word a
//   a    : word address
//   di   : write data
//   dout : read data, registered (read-before-write)
// Contents are deliberately not reset.
module hs32_bram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [31:0]   di,
    output logic [31:0]   dout
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= di;
        end
        dout <= mem[a];
    end

endmodule

// File: rtl/hs32_mem_target.sv
// hs32_mem_target: 32-bit word memory target with a valid/done handshake
// and a configurable number of wait states.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   addr  : byte address (addr[1:0] ignored)
//   rw    : 1 = write, 0 = read
//   din   : write data
//   dout  : read data, valid in the done cycle and held until the next one
//   valid : request strobe
//   done  : one-cycle completion pulse
// Parameters: AW word-address width, WAIT extra wait states (0..15),
// BASE byte address of word 0.
module hs32_mem_target
    import hs32_pkg::*;
#(
    parameter int          AW   = 10,
    parameter int          WAIT = 0,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rw,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        valid,
    output logic        done
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);
    localparam logic [32:0]      LIMIT    = 33'd4 << AW;

    hs32_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    idx_q;
    logic             rw_q;
    logic             hit_q;
    logic [31:0]      din_q;
    logic [31:0]      dout_q;
    logic [31:0]      ram_q;
    logic [31:0]      rd_val;
    logic [31:0]      offset;
    logic             hit;
    logic             ram_we;

    // Range check done on the byte offset so addresses below BASE wrap high
    // and fall outside the window along with those past the top.
    assign offset = addr - BASE;
    assign hit    = (addr >= BASE) && ({1'b0, offset} < LIMIT);

    assign ram_we = (state == S_ACCESS) && (rw_q == RW_WRITE) && hit_q;
    assign rd_val = hit_q ? ram_q : '0;

    // RAM data only arrives in the RESP cycle, so dout bypasses the holding
    // register there and the register captures it for the following cycles.
    assign dout = (state == S_RESP && rw_q == RW_READ) ? rd_val : dout_q;
    assign done = (state == S_RESP);

    hs32_bram #(
        .AW(AW)
    ) u_bram (
        .clk  (clk),
        .we   (ram_we),
        .a    (idx_q),
        .di   (din_q),
        .dout (ram_q)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    state_nxt = (WAIT_CNT != '0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt <= 1) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx_q  <= '0;
            rw_q   <= RW_READ;
            hit_q  <= 1'b0;
            din_q  <= '0;
            dout_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        idx_q <= offset[AW+1:2];
                        rw_q  <= rw;
                        hit_q <= hit;
                        din_q <= din;
                        cnt   <= WAIT_CNT;
                    end
                end
                S_WAIT: cnt <= cnt - 1'b1;
                S_RESP: begin
                    if (rw_q == RW_READ) begin
                        dout_q <= rd_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_mem_target.sv
// tb_hs32_mem_target: directed self-checking bench for hs32_mem_target.
// Four instances cover the parameter sets needed: WAIT=0, WAIT=3, WAIT=2
// and AW=4. Inputs addr/rw/din/reset are shared; each instance has its own
// valid so only one is active at a time.
module tb_hs32_mem_target;

    localparam int D_W0  = 0;
    localparam int D_W3  = 1;
    localparam int D_W2  = 2;
    localparam int D_AW4 = 3;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        rw;
    logic [31:0] din;
    logic [3:0]  valid;

    logic [31:0] dout_w0, dout_w3, dout_w2, dout_aw4;
    logic        done_w0, done_w3, done_w2, done_aw4;

    logic [3:0]  done_a;
    logic [31:0] dout_a [4];

    int total  = 0;
    int passed = 0;

    hs32_mem_target #(.AW(10), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .addr(addr), .rw(rw), .din(din),
        .dout(dout_w0), .valid(valid[D_W0]), .done(done_w0));

    hs32_mem_target #(.AW(10), .WAIT(3)) u_w3 (
        .clk(clk), .reset(reset), .addr(addr), .rw(rw), .din(din),
        .dout(dout_w3), .valid(valid[D_W3]), .done(done_w3));

    hs32_mem_target #(.AW(10), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset), .addr(addr), .rw(rw), .din(din),
        .dout(dout_w2), .valid(valid[D_W2]), .done(done_w2));

    hs32_mem_target #(.AW(4), .WAIT(0)) u_aw4 (
        .clk(clk), .reset(reset), .addr(addr), .rw(rw), .din(din),
        .dout(dout_aw4), .valid(valid[D_AW4]), .done(done_aw4));

    always_comb begin
        done_a    = {done_aw4, done_w2, done_w3, done_w0};
        dout_a[0] = dout_w0;
        dout_a[1] = dout_w3;
        dout_a[2] = dout_w2;
        dout_a[3] = dout_aw4;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One transaction on instance d. Starts with an idle edge, then drives
    // the request, drops valid and scrambles the bus right after acceptance.
    // lat = edges from acceptance edge count 1 to the done cycle (-1 if none).
    // one_pulse = done low one cycle after it was seen.
    task automatic txn(input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output int lat, output logic one_pulse);
        @(posedge clk); #1;
        addr = a; rw = w; din = wd; valid[d] = 1'b1;
        lat = -1; rd = '0; one_pulse = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                valid[d] = 1'b0;
                addr = 32'hFFFF_FFFC; rw = ~w; din = ~wd;
            end
            if (done_a[d]) begin
                lat = c;
                rd  = dout_a[d];
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            one_pulse = !done_a[d];
        end
    endtask

    task automatic test_reset;
        for (int d = 0; d < 4; d++) begin
            total++;
            if (done_a[d] !== 1'b0) $display("FAIL reset_done[%0d]: got %b expected 0", d, done_a[d]);
            else passed++;
            total++;
            if (dout_a[d] !== 32'h0) $display("FAIL reset_dout[%0d]: got %h expected 00000000", d, dout_a[d]);
            else passed++;
        end
    endtask

    task automatic test_write_read;
        logic [31:0] rd; int lat; logic p;
        txn(D_W0, 32'h10, 1'b1, 32'hDEAD_BEEF, rd, lat, p);
        total++;
        if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat); else passed++;
        total++;
        if (p !== 1'b1) $display("FAIL wr_done_pulse: got %b expected 1", p); else passed++;
        txn(D_W0, 32'h10, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (lat !== 2) $display("FAIL rd_latency: got %0d expected 2", lat); else passed++;
        total++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h expected deadbeef", rd); else passed++;
        total++;
        if (dout_a[D_W0] !== 32'hDEAD_BEEF) $display("FAIL dout_hold: got %h expected deadbeef", dout_a[D_W0]); else passed++;
        txn(D_W0, 32'h14, 1'b1, 32'h5, rd, lat, p);
        total++;
        if (dout_a[D_W0] !== 32'hDEAD_BEEF) $display("FAIL dout_after_write: got %h expected deadbeef", dout_a[D_W0]); else passed++;
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; int lat; logic p;
        txn(D_W3, 32'h0, 1'b1, 32'h77, rd, lat, p);
        total++;
        if (lat !== 5) $display("FAIL wait_wr_latency: got %0d expected 5", lat); else passed++;
        txn(D_W3, 32'h0, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (lat !== 5) $display("FAIL wait_rd_latency: got %0d expected 5", lat); else passed++;
        total++;
        if (p !== 1'b1) $display("FAIL wait_done_pulse: got %b expected 1", p); else passed++;
        total++;
        if (rd !== 32'h77) $display("FAIL wait_rd_data: got %h expected 00000077", rd); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; int lat; logic p;
        int n;
        int edges [3];
        logic [31:0] exp_v;
        n = 0;
        edges[0] = 0; edges[1] = 0; edges[2] = 0;
        @(posedge clk); #1;
        addr = 32'h0; din = 32'd1; rw = 1'b1; valid[D_W0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done_a[D_W0]) begin
                edges[n] = c;
                n++;
                if (n == 3) begin
                    valid[D_W0] = 1'b0;
                    break;
                end
                addr = 32'(4 * n);
                din  = 32'(n + 1);
            end
        end
        valid[D_W0] = 1'b0;
        total++;
        if (n !== 3) $display("FAIL b2b_done_count: got %0d expected 3", n); else passed++;
        total++;
        if (edges[0] !== 2) $display("FAIL b2b_first_done: got %0d expected 2", edges[0]); else passed++;
        total++;
        if (edges[1] - edges[0] !== 3) $display("FAIL b2b_spacing_1: got %0d expected 3", edges[1] - edges[0]); else passed++;
        total++;
        if (edges[2] - edges[1] !== 3) $display("FAIL b2b_spacing_2: got %0d expected 3", edges[2] - edges[1]); else passed++;
        for (int i = 0; i < 3; i++) begin
            exp_v = 32'(i + 1);
            txn(D_W0, 32'(4 * i), 1'b0, 32'h0, rd, lat, p);
            total++;
            if (rd !== exp_v) $display("FAIL b2b_readback[%0d]: got %h expected %h", i, rd, exp_v); else passed++;
        end
    endtask

    task automatic test_byte_offset;
        logic [31:0] rd; int lat; logic p;
        txn(D_W0, 32'h13, 1'b1, 32'h1234_5678, rd, lat, p);
        txn(D_W0, 32'h10, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (rd !== 32'h1234_5678) $display("FAIL byte_off_rd10: got %h expected 12345678", rd); else passed++;
        txn(D_W0, 32'h12, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (rd !== 32'h1234_5678) $display("FAIL byte_off_rd12: got %h expected 12345678", rd); else passed++;
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; int lat; logic p;
        txn(D_AW4, 32'h0,  1'b1, 32'hCAFE, rd, lat, p);
        txn(D_AW4, 32'h3C, 1'b1, 32'h0BEE, rd, lat, p);
        txn(D_AW4, 32'h40, 1'b1, 32'hFFFF, rd, lat, p);
        total++;
        if (lat !== 2) $display("FAIL oor_wr_latency: got %0d expected 2", lat); else passed++;
        total++;
        if (p !== 1'b1) $display("FAIL oor_wr_pulse: got %b expected 1", p); else passed++;
        txn(D_AW4, 32'h0, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (rd !== 32'hCAFE) $display("FAIL oor_word0_kept: got %h expected 0000cafe", rd); else passed++;
        txn(D_AW4, 32'h40, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (lat !== 2) $display("FAIL oor_rd_latency: got %0d expected 2", lat); else passed++;
        total++;
        if (rd !== 32'h0) $display("FAIL oor_rd_data: got %h expected 00000000", rd); else passed++;
        txn(D_AW4, 32'h3C, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (rd !== 32'h0BEE) $display("FAIL top_word_rd: got %h expected 00000bee", rd); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; int lat; logic p;
        int dones;
        txn(D_W2, 32'h8, 1'b1, 32'h11, rd, lat, p);
        txn(D_W2, 32'h8, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (lat !== 4) $display("FAIL w2_rd_latency: got %0d expected 4", lat); else passed++;
        total++;
        if (rd !== 32'h11) $display("FAIL w2_prior_value: got %h expected 00000011", rd); else passed++;
        @(posedge clk); #1;
        addr = 32'h8; rw = 1'b1; din = 32'hA5; valid[D_W2] = 1'b1;
        @(posedge clk); #1;
        valid[D_W2] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (dout_a[D_W2] !== 32'h0) $display("FAIL mid_reset_dout: got %h expected 00000000", dout_a[D_W2]); else passed++;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (done_a[D_W2]) dones++;
            @(posedge clk); #1;
        end
        total++;
        if (dones !== 0) $display("FAIL mid_reset_no_done: got %0d expected 0", dones); else passed++;
        txn(D_W2, 32'h8, 1'b0, 32'h0, rd, lat, p);
        total++;
        if (rd !== 32'h11) $display("FAIL mid_reset_no_write: got %h expected 00000011", rd); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        valid = '0;
        addr  = '0;
        rw    = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b0;
        test_write_read;
        test_wait_states;
        test_back_to_back;
        test_byte_offset;
        test_out_of_range;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
